mant_seq_mult: RTL and testbench

//  Sequential radix-2 shift-and-add mantissa multiplier for the FP multiply datapath.

---
 rtl/mult_pkg.sv | 20 ++
 rtl/cla_chain_adder.sv | 53 +++++
 rtl/mant_seq_mult.sv | 129 ++++++++++++
 tb/tb_mant_seq_mult.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the sequential mantissa multiplier.
//   MW_DEFAULT : default mantissa width (hidden bit included). It must be a
//                multiple of 4, the width of one CLA cell.
//   PW_DEFAULT : default product width (2*MW_DEFAULT).
//   state_t    : multiplier FSM encoding. ST_IDLE=0, ST_RUN=1, ST_DONE=2.
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MW_DEFAULT = 24;
  localparam int PW_DEFAULT = 2 * MW_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_chain_adder.sv
// ---------------------------------------------------------------------------
// cla_chain_adder
//   W-bit adder built from W/4 ripple-chained 4-bit carry-lookahead cells.
//   Inside a cell, every carry is computed directly from that cell's
//   generate/propagate terms and its carry-in.
//   Ports:
//     i_a, i_b : W-bit addends
//     i_cin    : carry into cell 0
//     o_sum    : W-bit sum
//     o_cout   : carry out of the last cell
//   W must be a multiple of 4.
// ---------------------------------------------------------------------------
module cla_chain_adder #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  localparam int NC = W / 4;

  // w_c[k] is the carry into cell k.
  logic [NC:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar k = 0; k < NC; k++) begin : g_cell
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_cc;

    assign w_g = i_a[4*k +: 4] & i_b[4*k +: 4];
    assign w_p = i_a[4*k +: 4] ^ i_b[4*k +: 4];

    assign w_cc[0] = w_c[k];
    assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
    assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
    assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);

    assign o_sum[4*k +: 4] = w_p ^ w_cc[3:0];
    assign w_c[k+1]        = w_cc[4];
  end

  assign o_cout = w_c[NC];

endmodule

// File: rtl/mant_seq_mult.sv
// ---------------------------------------------------------------------------
// mant_seq_mult
//   Radix-2 shift-and-add multiplier for unsigned MW-bit mantissas. It
//   returns the 2*MW-bit product. It retires one multiplier bit per RUN
//   cycle through a single cla_chain_adder.
//   Ports:
//     clk, rst    : clock; asynchronous active-high reset
//     in_valid    : operands a/b are offered
//     in_ready    : the block takes operands on this cycle's edge if in_valid
//     a, b        : multiplicand / multiplier mantissas
//     out_valid   : product p is presented
//     out_ready   : downstream takes p on this cycle's edge if out_valid
//     p           : product a*b
//     o_dbg_state : current FSM state
//   Optional macro MANT_MULT_EARLY_TERM_EN: when defined, the block finishes
//   early once the remaining multiplier bits are zero. Products are identical
//   in both builds.
// ---------------------------------------------------------------------------
module mant_seq_mult
  import mult_pkg::*;
#(
  parameter int MW = MW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW-1:0]   a,
  input  logic [MW-1:0]   b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*MW-1:0] p,
  output state_t          o_dbg_state
);

  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [MW-1:0] r_mcand;
  logic [MW-1:0] r_acc_hi;
  logic [MW-1:0] r_acc_lo;
  logic [CW-1:0] r_cnt;

  logic [MW-1:0] w_addend;
  logic [MW-1:0] w_sum;
  logic          w_cout;
  logic [PW-1:0] w_step;
  logic [PW-1:0] w_run_val;
  logic [CW-1:0] w_run_cnt;
  logic          w_accept;
  logic          w_last;

  // Handshake: a transfer happens on a rising edge where valid & ready are
  // both high. Input side: in_ready depends only on state and out_ready,
  // never on in_valid. Output side: once out_valid rises, p and out_valid
  // hold until the edge on which out_ready is seen high.
  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign p         = {r_acc_hi, r_acc_lo};
  assign o_dbg_state = r_state;

  assign w_addend = r_acc_lo[0] ? r_mcand : '0;

  cla_chain_adder #(.W(MW)) u_adder (
    .i_a    (r_acc_hi),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // One radix-2 step: the new partial product drops into acc_hi, and the
  // consumed multiplier bit falls off the bottom of acc_lo.
  assign w_step = {w_cout, w_sum, r_acc_lo[MW-1:1]};

`ifdef MANT_MULT_EARLY_TERM_EN
  logic [MW-1:0] w_rest_mask;
  logic          w_early;

  // This cycle's bit acc_lo[0] is added as usual. Only the bits above it,
  // up to cnt-1, need to be clear to finish now. The remaining cnt-1 steps
  // would then add nothing, so they collapse into a single shift of the
  // stepped accumulator.
  assign w_rest_mask = ~({MW{1'b1}} << r_cnt) & ~MW'(1);
  assign w_early     = ((r_acc_lo & w_rest_mask) == '0);
  assign w_run_val   = w_early ? (w_step >> (r_cnt - CW'(1))) : w_step;
  assign w_run_cnt   = w_early ? '0 : (r_cnt - CW'(1));
  assign w_last      = w_early | (r_cnt == CW'(1));
`else
  assign w_run_val = w_step;
  assign w_run_cnt = r_cnt - CW'(1);
  assign w_last    = (r_cnt == CW'(1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = in_valid ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_mcand  <= a;
        r_acc_hi <= '0;
        r_acc_lo <= b;
        r_cnt    <= CW'(MW);
      end else if (r_state == ST_RUN) begin
        {r_acc_hi, r_acc_lo} <= w_run_val;
        r_cnt                <= w_run_cnt;
      end
    end
  end

endmodule

// File: tb/tb_mant_seq_mult.sv
`timescale 1ns/1ps
module tb_mant_seq_mult;
  import mult_pkg::*;

  localparam int MW = 24;
  localparam int PW = 48;
`ifdef MANT_MULT_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [MW-1:0] a = '0;
  logic [MW-1:0] b = '0;
  logic [PW-1:0] p;
  state_t        dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mant_seq_mult #(.MW(MW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [PW-1:0] exp_q[$];
  bit            m_busy = 1'b0;
  int            m_ready_cyc = 0;
  bit            prev_hold = 1'b0;
  logic [PW-1:0] prev_p = '0;
  bit            exp_ov;
  bit            exp_ir;

  // out_ready has a single owner process. Other code sets rand_or/or_fixed.
  bit   rand_or = 1'b0;
  logic or_fixed = 1'b1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  // Clock edges from the accept edge to out_valid. Without early
  // termination this is always MW. With it, the run ends on the edge that
  // consumes the highest set multiplier bit, or after one edge when b is 0.
  function automatic int lat_edges(input logic [MW-1:0] bb);
    int n;
    n = MW;
`ifdef MANT_MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < MW; i++) if (bb[i]) n = i + 1;
`endif
    return n;
  endfunction

  function automatic logic [MW-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return MW'($urandom_range(0, 255));
      3: return MW'(1) << $urandom_range(0, MW - 1);
      default: return MW'($urandom);
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_or ? ($urandom_range(0, 3) != 0) : or_fixed;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_busy    = 1'b0;
      prev_hold = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_p", p, 0);
      chk("rst_state", dbg_state, ST_IDLE);
    end else begin
      exp_ov = m_busy && (cyc >= m_ready_cyc);
      exp_ir = !m_busy || (exp_ov && out_ready);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, exp_ir);
      if (prev_hold) chk("p_hold", p, prev_p);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("product", p, exp_q.pop_front());
        m_busy = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(PW'(a) * PW'(b));
        m_busy      = 1'b1;
        m_ready_cyc = cyc + 1 + lat_edges(b);
      end
      prev_hold = out_valid && !out_ready;
      prev_p    = p;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_out(output int t, output logic [PW-1:0] got);
    t   = -1;
    got = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        t   = cyc;
        got = p;
        break;
      end
    end
    if (t < 0) chk("out_timeout", 0, 1);
  endtask

  // Latency is counted from the edge that opens the accept cycle to the
  // edge after which out_valid is high.
  task automatic run_one(input string name, input logic [MW-1:0] op_a, input logic [MW-1:0] op_b,
                         input logic [PW-1:0] exp_p, input int exp_lat);
    int            t_acc;
    int            t_out;
    logic [PW-1:0] got;
    @(posedge clk); #1;
    a = op_a; b = op_b; in_valid = 1'b1;
    wait_accept(t_acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(t_out, got);
    chk({name, "_p"}, got, exp_p);
    chk({name, "_lat"}, t_out - t_acc, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            t_acc;
    int            t_out;
    int            stale;
    int            gap;
    logic [PW-1:0] got;
    logic [PW-1:0] hold_p;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    or_fixed = 1'b1;

    run_one("msb",    24'h800000, 24'h800000, 48'h400000000000, 25);
    run_one("ones",   24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 25);
    run_one("b_one",  24'hABCDEF, 24'h000001, 48'h000000ABCDEF, ET ? 2 : 25);
    run_one("b_zero", 24'h123456, 24'h000000, 48'h000000000000, ET ? 2 : 25);
    run_one("b_256",  24'hFFFFFF, 24'h000100, 48'h0000FFFFFF00, ET ? 10 : 25);
    run_one("a_one",  24'h000001, 24'hFFFFFF, 48'h000000FFFFFF, 25);

    // Backpressure: hold DONE for 10 cycles while new operands wait.
    or_fixed = 1'b0;
    @(posedge clk); #1;
    a = 24'hC0FFEE; b = 24'h9ABCDE; in_valid = 1'b1;
    wait_accept(t_acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(t_out, hold_p);
    @(posedge clk); #1;
    a = 24'h000003; b = 24'h000005; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_p", p, hold_p);
      chk("bp_in_ready", in_ready, 0);
    end
    or_fixed = 1'b1;
    wait_accept(t_acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(t_out, got);
    chk("bp_next_p", got, 48'h00000000000F);
    chk("bp_next_lat", t_out - t_acc, ET ? 4 : 25);

    // Reset seven cycles into RUN.
    @(posedge clk); #1;
    a = 24'h777777; b = 24'hC00000; in_valid = 1'b1;
    wait_accept(t_acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", stale, 0);

    // Random operands, random gaps, random out_ready.
    rand_or = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      @(posedge clk); #1;
      a = rand_op(); b = rand_op(); in_valid = 1'b1;
      wait_accept(t_acc);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = MW'($urandom);
      b = MW'($urandom);
    end
    rand_or  = 1'b0;
    or_fixed = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
